// File: rtl/vdp_vram_arbiter_if.sv
// Bus bundle between the VDP fetch units/CPU port, the VRAM arbiter and the VRAM macro.
// The slave modport is the arbiter; the master modport is the requester and VRAM side.
interface vdp_vram_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              vblank;
    logic              bg_req;
    logic [ADDR_W-1:0] bg_addr;
    logic              spr_req;
    logic [ADDR_W-1:0] spr_addr;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              bg_gnt;
    logic              spr_gnt;
    logic              cpu_gnt;
    logic              bg_valid;
    logic              spr_valid;
    logic              cpu_valid;
    logic [DATA_W-1:0] rdata;
    logic              vram_en;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_wdata;
    logic [DATA_W-1:0] vram_rdata;

    modport slave (
        input  vblank, bg_req, bg_addr, spr_req, spr_addr,
               cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
        output bg_gnt, spr_gnt, cpu_gnt, bg_valid, spr_valid, cpu_valid,
               rdata, vram_en, vram_we, vram_addr, vram_wdata
    );

    modport master (
        output vblank, bg_req, bg_addr, spr_req, spr_addr,
               cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
        input  bg_gnt, spr_gnt, cpu_gnt, bg_valid, spr_valid, cpu_valid,
               rdata, vram_en, vram_we, vram_addr, vram_wdata
    );
endinterface

// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM arbiter for BG fetch, SPR fetch and the CPU port, one access in flight.
// Define VDP_ARB_STARVE_GUARD_EN to let a long-waiting CPU request override priority.
module vdp_vram_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 16
) (
    input logic               clk,
    input logic               rst,
    vdp_vram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_BG, OWN_SPR, OWN_CPU} owner_t;

    state_t            state, state_nx;
    owner_t            owner, owner_nx, winner;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic              we_q, we_nx;
    logic [DATA_W-1:0] wdata_q, wdata_nx;
    logic [DATA_W-1:0] rdata_q, rdata_nx;
    logic [2:0]        cnt_q, cnt_nx;
    logic              cpu_first;
    logic              arb_slot;

    if (RD_LAT < 1 || RD_LAT > 7 || STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_param
        $error("vdp_vram_arbiter: RD_LAT or STARVE_MAX out of range");
    end

`ifdef VDP_ARB_STARVE_GUARD_EN
    logic [7:0] cpu_wait;

    always_ff @(posedge clk) begin
        if (rst || !bus.cpu_req || bus.cpu_gnt) begin
            cpu_wait <= '0;
        end else if (cpu_wait != 8'(STARVE_MAX)) begin
            cpu_wait <= cpu_wait + 8'd1;
        end
    end

    assign cpu_first = bus.vblank || (cpu_wait == 8'(STARVE_MAX));
`else
    assign cpu_first = bus.vblank;
`endif

    assign arb_slot = (state == IDLE) || (state == DONE);

    // During vblank (or a starved CPU) the CPU jumps ahead; otherwise it is served last.
    always_comb begin
        winner = OWN_NONE;
        if (cpu_first && bus.cpu_req) begin
            winner = OWN_CPU;
        end else if (bus.bg_req) begin
            winner = OWN_BG;
        end else if (bus.spr_req) begin
            winner = OWN_SPR;
        end else if (bus.cpu_req) begin
            winner = OWN_CPU;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        addr_nx  = addr_q;
        we_nx    = we_q;
        wdata_nx = wdata_q;
        cnt_nx   = cnt_q;
        rdata_nx = rdata_q;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                owner_nx = OWN_NONE;
                case (winner)
                    OWN_BG: begin
                        state_nx = ISSUE;
                        owner_nx = OWN_BG;
                        addr_nx  = bus.bg_addr;
                        we_nx    = 1'b0;
                        wdata_nx = '0;
                    end
                    OWN_SPR: begin
                        state_nx = ISSUE;
                        owner_nx = OWN_SPR;
                        addr_nx  = bus.spr_addr;
                        we_nx    = 1'b0;
                        wdata_nx = '0;
                    end
                    OWN_CPU: begin
                        state_nx = ISSUE;
                        owner_nx = OWN_CPU;
                        addr_nx  = bus.cpu_addr;
                        we_nx    = bus.cpu_we;
                        wdata_nx = bus.cpu_we ? bus.cpu_wdata : '0;
                    end
                    default: ;
                endcase
            end
            ISSUE: begin
                if (we_q) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx   = 3'(RD_LAT - 1);
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    rdata_nx = bus.vram_rdata;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt_q - 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= OWN_NONE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_nx;
            owner   <= owner_nx;
            addr_q  <= addr_nx;
            we_q    <= we_nx;
            wdata_q <= wdata_nx;
            cnt_q   <= cnt_nx;
            rdata_q <= rdata_nx;
        end
    end

    // Strobes are gated by rst so nothing leaks out while reset is held.
    always_comb begin
        bus.bg_gnt     = 1'b0;
        bus.spr_gnt    = 1'b0;
        bus.cpu_gnt    = 1'b0;
        bus.bg_valid   = 1'b0;
        bus.spr_valid  = 1'b0;
        bus.cpu_valid  = 1'b0;
        bus.vram_en    = 1'b0;
        bus.vram_we    = 1'b0;
        bus.vram_addr  = '0;
        bus.vram_wdata = '0;
        if (!rst) begin
            if (arb_slot) begin
                bus.bg_gnt  = (winner == OWN_BG);
                bus.spr_gnt = (winner == OWN_SPR);
                bus.cpu_gnt = (winner == OWN_CPU);
            end
            if (state == DONE) begin
                bus.bg_valid  = (owner == OWN_BG);
                bus.spr_valid = (owner == OWN_SPR);
                bus.cpu_valid = (owner == OWN_CPU);
            end
            if (state == ISSUE) begin
                bus.vram_en    = 1'b1;
                bus.vram_we    = we_q;
                bus.vram_addr  = addr_q;
                bus.vram_wdata = wdata_q;
            end
        end
    end

    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Testbench for vdp_vram_arbiter: vector table plus scoreboard, with reset,
// withdrawal and starvation sequences. Honours VDP_ARB_STARVE_GUARD_EN.
module tb_vdp_vram_arbiter;
    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 8;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 16;
    localparam logic [1:0] OB = 2'd1;
    localparam logic [1:0] OS = 2'd2;
    localparam logic [1:0] OC = 2'd3;

    typedef struct {
        logic       vblank;
        logic [2:0] req;
        logic       cpu_we;
        logic [13:0] bg_addr;
        logic [13:0] spr_addr;
        logic [13:0] cpu_addr;
        logic [7:0] cpu_wdata;
        int         n;
        logic [1:0] ord [3];
    } vec_t;

    typedef struct {
        logic [1:0]  owner;
        logic        we;
        logic [13:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  data;
        logic        b2b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    logic mon_en;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t exp_q[$];
    exp_t cur;
    logic cur_act = 1'b0;
    int   gnt_cyc = 0;
    int   last_valid_cyc = 0;
    logic [7:0] last_rd = 8'h00;
    int   gcnt [4];
    int   vcnt [4];
    logic [7:0] ref_mem [int];
    vec_t vecs [10];

    vdp_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vdp_vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input logic [13:0] a);
        if (a == 14'h3F00) return 8'h5A;
        return a[7:0] ^ {a[13:8], 2'b10};
    endfunction

    function automatic logic [7:0] ref_rd(input logic [13:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return pat(a);
    endfunction

    // VRAM model: data appears exactly RD_LAT cycles after the issue cycle, for one cycle.
    logic [7:0] vmem [0:16383];
    logic [7:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16384; i++) vmem[i] <= pat(14'(i));
            for (int k = 0; k < RD_LAT; k++) rd_pipe[k] <= 8'h00;
        end else begin
            if (bus.vram_en && bus.vram_we) vmem[bus.vram_addr] <= bus.vram_wdata;
            rd_pipe[0] <= (bus.vram_en && !bus.vram_we) ? vmem[bus.vram_addr] : 8'h00;
            for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
    end
    assign bus.vram_rdata = rd_pipe[RD_LAT-1];

    task automatic check_output(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int ng, nv;
        logic [1:0] go, vo;
        exp_t it;
        if (mon_en) begin
            ng = int'(bus.bg_gnt) + int'(bus.spr_gnt) + int'(bus.cpu_gnt);
            nv = int'(bus.bg_valid) + int'(bus.spr_valid) + int'(bus.cpu_valid);
            check_output("one_gnt", int'(ng <= 1), 1);
            check_output("one_valid", int'(nv <= 1), 1);
            if (!bus.vram_en)
                check_output("idle_bus", {bus.vram_we, bus.vram_addr, bus.vram_wdata}, 0);
            if (nv != 0) begin
                vo = bus.bg_valid ? OB : (bus.spr_valid ? OS : OC);
                vcnt[vo]++;
                check_output("stray_valid", int'(cur_act), 1);
                if (cur_act) begin
                    check_output("valid_owner", vo, cur.owner);
                    check_output("valid_latency", cyc - gnt_cyc, cur.we ? 2 : 2 + RD_LAT);
                    if (cur.we) begin
                        check_output("rdata_hold", bus.rdata, last_rd);
                    end else begin
                        check_output("rdata", bus.rdata, cur.data);
                        last_rd = cur.data;
                    end
                    cur_act = 1'b0;
                end
                last_valid_cyc = cyc;
            end
            if (bus.vram_en) begin
                check_output("stray_issue", int'(cur_act), 1);
                if (cur_act) begin
                    check_output("issue_cycle", cyc - gnt_cyc, 1);
                    check_output("issue_addr", bus.vram_addr, cur.addr);
                    check_output("issue_we", bus.vram_we, cur.we);
                    check_output("issue_wdata", bus.vram_wdata, cur.we ? cur.wdata : 8'h00);
                end
            end
            if (ng != 0) begin
                go = bus.bg_gnt ? OB : (bus.spr_gnt ? OS : OC);
                gcnt[go]++;
                check_output("gnt_overlap", int'(cur_act), 0);
                check_output("gnt_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    it = exp_q.pop_front();
                    check_output("gnt_owner", go, it.owner);
                    if (it.b2b) check_output("b2b_gap", cyc - last_valid_cyc, 0);
                    cur = it;
                    cur_act = 1'b1;
                    gnt_cyc = cyc;
                end
            end
        end
    end

    function automatic vec_t mk(input logic vb, input logic [2:0] req, input logic we,
                                input logic [13:0] ba, input logic [13:0] sa,
                                input logic [13:0] ca, input logic [7:0] wd, input int n,
                                input logic [1:0] o0, input logic [1:0] o1,
                                input logic [1:0] o2);
        vec_t v;
        v.vblank = vb; v.req = req; v.cpu_we = we;
        v.bg_addr = ba; v.spr_addr = sa; v.cpu_addr = ca; v.cpu_wdata = wd;
        v.n = n; v.ord[0] = o0; v.ord[1] = o1; v.ord[2] = o2;
        return v;
    endfunction

    task automatic wait_idle(input string tag);
        int c = 0;
        while ((cur_act || exp_q.size() != 0) && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (cur_act || exp_q.size() != 0) begin
            check_output(tag, 1, 0);
            exp_q.delete();
            cur_act = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        exp_t it;
        logic [2:0] pending, g;
        for (int k = 0; k < v.n; k++) begin
            it.owner = v.ord[k];
            it.we = 1'b0; it.wdata = 8'h00; it.data = 8'h00; it.b2b = (k > 0);
            case (v.ord[k])
                OB: it.addr = v.bg_addr;
                OS: it.addr = v.spr_addr;
                default: begin
                    it.addr = v.cpu_addr; it.we = v.cpu_we; it.wdata = v.cpu_wdata;
                end
            endcase
            if (it.we) ref_mem[int'(it.addr)] = it.wdata;
            else it.data = ref_rd(it.addr);
            exp_q.push_back(it);
        end
        @(posedge clk); #1;
        bus.vblank = v.vblank;
        bus.bg_req = v.req[0]; bus.bg_addr = v.bg_addr;
        bus.spr_req = v.req[1]; bus.spr_addr = v.spr_addr;
        bus.cpu_req = v.req[2]; bus.cpu_addr = v.cpu_addr;
        bus.cpu_we = v.cpu_we; bus.cpu_wdata = v.cpu_wdata;
        pending = v.req;
        for (int c = 0; c < 100 && pending != 3'b000; c++) begin
            @(negedge clk);
            g = {bus.cpu_gnt, bus.spr_gnt, bus.bg_gnt};
            @(posedge clk); #1;
            if (g[0]) begin bus.bg_req = 1'b0; bus.bg_addr = 14'($urandom); end
            if (g[1]) begin bus.spr_req = 1'b0; bus.spr_addr = 14'($urandom); end
            if (g[2]) begin
                bus.cpu_req = 1'b0; bus.cpu_addr = 14'($urandom);
                bus.cpu_we = 1'($urandom); bus.cpu_wdata = 8'($urandom);
            end
            pending = pending & ~g;
        end
        if (pending != 3'b000) begin
            check_output("gnt_timeout", pending, 0);
            bus.bg_req = 1'b0; bus.spr_req = 1'b0; bus.cpu_req = 1'b0;
        end
        bus.cpu_we = 1'b0;
        wait_idle("done_timeout");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t it;
        int s0, v0, b0, first;
        logic got;
        for (int i = 0; i < 4; i++) begin gcnt[i] = 0; vcnt[i] = 0; end
        rst = 1'b1; mem_init = 1'b1; mon_en = 1'b0;
        bus.vblank = 1'b0; bus.bg_req = 1'b1; bus.bg_addr = 14'h0001;
        bus.spr_req = 1'b0; bus.spr_addr = '0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        check_output("rst_gnt", {bus.bg_gnt, bus.spr_gnt, bus.cpu_gnt}, 0);
        check_output("rst_vram_en", bus.vram_en, 0);
        check_output("rst_rdata", bus.rdata, 0);
        @(posedge clk); #1;
        bus.bg_req = 1'b0; rst = 1'b0; mon_en = 1'b1;

        vecs[0] = mk(0, 3'b001, 0, 14'h3F00, 14'h0000, 14'h0000, 8'h00, 1, OB, 0, 0);
        vecs[1] = mk(0, 3'b100, 1, 14'h0000, 14'h0000, 14'h1234, 8'hA5, 1, OC, 0, 0);
        vecs[2] = mk(0, 3'b100, 0, 14'h0000, 14'h0000, 14'h1234, 8'h00, 1, OC, 0, 0);
        vecs[3] = mk(0, 3'b111, 0, 14'h0010, 14'h0020, 14'h0030, 8'h00, 3, OB, OS, OC);
        vecs[4] = mk(1, 3'b111, 1, 14'h0040, 14'h0050, 14'h0060, 8'h3C, 3, OC, OB, OS);
        vecs[5] = mk(0, 3'b110, 0, 14'h0000, 14'h0070, 14'h0060, 8'h00, 2, OS, OC, 0);
        vecs[6] = mk(1, 3'b011, 0, 14'h0080, 14'h0090, 14'h0000, 8'h00, 2, OB, OS, 0);
        vecs[7] = mk(1, 3'b110, 1, 14'h0000, 14'h00A0, 14'h00A0, 8'hC3, 2, OC, OS, 0);
        vecs[8] = mk(0, 3'b101, 1, 14'h00B0, 14'h0000, 14'h00B0, 8'h77, 2, OB, OC, 0);
        vecs[9] = mk(0, 3'b010, 0, 14'h0000, 14'h0155, 14'h0000, 8'h00, 1, OS, 0, 0);
        for (int i = 0; i < 10; i++) apply_stimulus(vecs[i]);

        // Withdrawal: SPR request comes and goes while BG sits in WAIT.
        bus.vblank = 1'b0;
        s0 = gcnt[OS]; v0 = vcnt[OS]; b0 = vcnt[OB];
        it.owner = OB; it.we = 1'b0; it.addr = 14'h0A0A; it.wdata = 8'h00;
        it.data = ref_rd(14'h0A0A); it.b2b = 1'b0;
        exp_q.push_back(it);
        bus.bg_req = 1'b1; bus.bg_addr = 14'h0A0A;
        @(negedge clk);
        @(posedge clk); #1;
        bus.bg_req = 1'b0; bus.bg_addr = 14'h2222;
        @(posedge clk); #1;
        bus.spr_req = 1'b1; bus.spr_addr = 14'h0777;
        @(posedge clk); #1;
        bus.spr_req = 1'b0;
        wait_idle("withdraw_timeout");
        check_output("withdraw_spr_gnt", gcnt[OS] - s0, 0);
        check_output("withdraw_spr_valid", vcnt[OS] - v0, 0);
        check_output("dropped_req_valid", vcnt[OB] - b0, 1);

        // Reset in the middle of a read abandons it cleanly.
        mon_en = 1'b0;
        bus.bg_req = 1'b1; bus.bg_addr = 14'h0100;
        @(negedge clk);
        check_output("rst_seq_gnt", bus.bg_gnt, 1);
        @(posedge clk); #1;
        bus.bg_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; bus.bg_req = 1'b1; bus.bg_addr = 14'h0200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("rst_mid_gnt", {bus.bg_gnt, bus.spr_gnt, bus.cpu_gnt}, 0);
            check_output("rst_mid_valid", {bus.bg_valid, bus.spr_valid, bus.cpu_valid}, 0);
            check_output("rst_mid_vram_en", bus.vram_en, 0);
            if (i > 0) check_output("rst_mid_rdata", bus.rdata, 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; last_rd = 8'h00; cur_act = 1'b0; exp_q.delete();
        it.owner = OB; it.we = 1'b0; it.addr = 14'h0200; it.wdata = 8'h00;
        it.data = ref_rd(14'h0200); it.b2b = 1'b0;
        exp_q.push_back(it);
        mon_en = 1'b1;
        @(negedge clk);
        check_output("post_rst_gnt", bus.bg_gnt, 1);
        @(posedge clk); #1;
        bus.bg_req = 1'b0;
        wait_idle("post_rst_timeout");

        // Starvation: BG held continuously while the CPU waits.
        mon_en = 1'b0;
        bus.vblank = 1'b0; bus.bg_req = 1'b1; bus.bg_addr = 14'h0300;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0400;
        first = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.cpu_gnt && first < 0) first = i;
            @(posedge clk); #1;
            if (first >= 0) bus.cpu_req = 1'b0;
        end
`ifdef VDP_ARB_STARVE_GUARD_EN
        check_output("starve_gnt", int'(first >= 0 && first <= STARVE_MAX + RD_LAT + 3), 1);
`else
        check_output("starve_none", first, -1);
`endif
        bus.bg_req = 1'b0;
        got = (first >= 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.cpu_gnt) got = 1'b1;
            @(posedge clk); #1;
            if (got) bus.cpu_req = 1'b0;
        end
        check_output("starve_release", got, 1);
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
